// File: rtl/sparc_mem_if.sv
// Request/response and byte-RAM signals of the SPARC memory sequencer.
// master: control unit plus RAM model; slave: the sequencer itself.
interface sparc_mem_if #(
  parameter int ADDR_W = 9
);
  logic              mfa;
  logic              rw;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              mfc;
  logic              align_trap;
  logic              busy;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport master (
    output mfa, rw, size, sign_ext, addr, wdata, ram_rdata,
    input  rdata, mfc, align_trap, busy, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  mfa, rw, size, sign_ext, addr, wdata, ram_rdata,
    output rdata, mfc, align_trap, busy, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/sparc_mem_ctrl.sv
// Load/store sequencer: splits aligned byte/half/word requests into big-endian
// byte slots on a byte-wide RAM, with WAIT_CYCLES extra cycles per slot.
module sparc_mem_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input logic       clk,
  input logic       reset,
  sparc_mem_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACCESS, DONE, TRAP, RELEASE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t          state;
  logic            l_rw;
  logic            l_sext;
  logic [1:0]      l_size;
  logic [31:0]     l_wdata;
  logic [1:0]      idx;
  logic [1:0]      last_idx;
  logic [3:0]      wc;
  logic [3:0][7:0] bytes_q;

  logic [3:0][7:0] lb;
  logic            ext;
  logic [31:0]     ld_word;
  logic            misaligned;

  // Byte j of a store, most significant byte of the operand first.
  function automatic logic [7:0] store_byte(input logic [31:0] wd, input logic [1:0] sz,
                                            input logic [1:0] j);
    case (sz)
      2'b10: begin
        case (j)
          2'd0:    return wd[31:24];
          2'd1:    return wd[23:16];
          2'd2:    return wd[15:8];
          default: return wd[7:0];
        endcase
      end
      2'b01:   return j[0] ? wd[7:0] : wd[15:8];
      default: return wd[7:0];
    endcase
  endfunction

  assign misaligned = (bus.size == 2'b11) ||
                      (bus.size == 2'b01 && bus.addr[0]) ||
                      (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);

  // Final load word, folding in the byte arriving on the current edge.
  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    lb      = bytes_q;
    lb[idx] = bus.ram_rdata;
    ext     = l_sext & lb[0][7];
    case (l_size)
      2'b10:   ld_word = {lb[0], lb[1], lb[2], lb[3]};
      2'b01:   ld_word = {{16{ext}}, lb[0], lb[1]};
      default: ld_word = {{24{ext}}, lb[0]};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      l_rw           <= 1'b0;
      l_sext         <= 1'b0;
      l_size         <= 2'b00;
      l_wdata        <= '0;
      idx            <= '0;
      last_idx       <= '0;
      wc             <= '0;
      // NOTE: the 4-byte capture buffer is small enough to reset along with everything else.
      bytes_q        <= '0;
      bus.rdata      <= '0;
      bus.mfc        <= 1'b0;
      bus.align_trap <= 1'b0;
      bus.busy       <= 1'b0;
      bus.ram_en     <= 1'b0;
      bus.ram_we     <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
    end else begin
      bus.mfc        <= 1'b0;
      bus.align_trap <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mfa) begin
            l_rw     <= bus.rw;
            l_sext   <= bus.sign_ext;
            l_size   <= bus.size;
            l_wdata  <= bus.wdata;
            bus.busy <= 1'b1;
            if (misaligned) begin
              state          <= TRAP;
              bus.align_trap <= 1'b1;
            end else begin
              state         <= ACCESS;
              idx           <= '0;
              wc            <= '0;
              last_idx      <= (bus.size == 2'b10) ? 2'd3 : {1'b0, bus.size[0]};
              bus.ram_en    <= 1'b1;
              bus.ram_we    <= ~bus.rw;
              bus.ram_addr  <= bus.addr;
              bus.ram_wdata <= store_byte(bus.wdata, bus.size, 2'd0);
            end
          end
        end
        ACCESS: begin
          if (wc == WAIT_LAST) begin
            if (l_rw) bytes_q[idx] <= bus.ram_rdata;
            if (idx == last_idx) begin
              state      <= DONE;
              bus.ram_en <= 1'b0;
              bus.ram_we <= 1'b0;
              bus.mfc    <= 1'b1;
              if (l_rw) bus.rdata <= ld_word;
            end else begin
              idx           <= idx + 2'd1;
              wc            <= '0;
              bus.ram_addr  <= bus.ram_addr + ADDR_W'(1);
              bus.ram_wdata <= store_byte(l_wdata, l_size, idx + 2'd1);
            end
          end else begin
            wc <= wc + 4'd1;
          end
        end
        DONE:    state <= RELEASE;
        TRAP:    state <= RELEASE;
        RELEASE: begin
          // Wait for the request to drop so a held mfa cannot retrigger.
          if (!bus.mfa) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sparc_mem_ctrl.md
Name: sparc_mem_ctrl

Overview:
- Memory-access sequencer between the SPARC control unit and the byte-wide data RAM of the DataPath.
- Accepts one load/store request at a time over an MFA/MFC handshake and checks alignment.
- Splits byte, halfword and word accesses into big-endian byte cycles with programmable wait states.
- Returns sign- or zero-extended load data and raises mfc on completion, or align_trap on a misaligned request.

Parameters:
ADDR_W, 9, byte-address width of RAM (512 bytes)
WAIT_CYCLES, 1, extra cycles per byte slot; each slot lasts WAIT_CYCLES+1 cycles; legal range 0..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mfa  in  1  memory function active; request held high until mfc/align_trap
rw  in  1  1 = load, 0 = store
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  in  ADDR_W  byte address of the access
wdata  in  32  store data, right-justified
rdata  out  32  load result; held until the next completed load
mfc  out  1  memory function complete, one-cycle pulse
align_trap  out  1  one-cycle pulse on misaligned or illegal request
busy  out  1  high in every state except IDLE
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM byte address
ram_wdata  out  8  RAM write byte
ram_rdata  in  8  RAM read byte, combinational while ram_en is high

Behaviour:
- Reset (async), all outputs 0: rdata, mfc, align_trap, busy, ram_en, ram_we, ram_addr, ram_wdata. State goes to IDLE; byte index and wait counter clear.
- Reset mid-access: ram_en/ram_we drop immediately; a partial store stays partially written; no mfc is issued.
- States: IDLE, ACCESS, DONE, TRAP, RELEASE.
- IDLE, mfa=1 at a clock edge: latch rw, size, sign_ext, addr, wdata.
  - size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0 -> TRAP.
  - Otherwise -> ACCESS with n = 1, 2 or 4 bytes and byte index i=0.
- TRAP: align_trap=1 and mfc=0 for exactly one cycle; no RAM activity; -> RELEASE.
- ACCESS:
  - ram_en=1, ram_addr = latched addr + i (computed in ADDR_W bits, wraps modulo 2^ADDR_W), ram_we = ~rw for the whole slot.
  - Store byte i is big-endian: word -> wdata[31-8i -: 8]; half -> wdata[15-8i -: 8]; byte -> wdata[7:0].
  - Each slot lasts WAIT_CYCLES+1 cycles. On the last cycle of a load slot, capture ram_rdata into byte i.
  - After slot n-1 -> DONE; otherwise i increments and the next slot starts the following cycle with no idle gap.
- DONE: mfc=1 for one cycle, ram_en=0.
  - On a load, rdata updates at the DONE edge:
    - word: {b0,b1,b2,b3}
    - half: {16{ext}, b0, b1}
    - byte: {24{ext}, b0}
    - ext = sign_ext ? MSB of b0 : 0.
  - Stores leave rdata unchanged. -> RELEASE.
- RELEASE: wait for mfa=0, then -> IDLE. A request held high past mfc/align_trap never retriggers.
- Latency from the edge sampling mfa=1 in IDLE to mfc high: n*(WAIT_CYCLES+1)+1 cycles. For a trap, align_trap is high in the next cycle.
- Input changes while busy are ignored; only latched values are used.

Test Plan:
- WAIT_CYCLES=1: store word 0xDEADBEEF at addr 0x010 -> four 2-cycle slots writing DE,AD,BE,EF to 0x010..0x013; mfc in cycle 9. Then load word at 0x010 -> rdata=0xDEADBEEF.
- Store byte 0x80 at 0x021, then load byte with sign_ext=1 -> rdata=0xFFFFFF80; with sign_ext=0 -> 0x00000080. mfc 3 cycles after request.
- Load halfword at 0x023 -> align_trap one cycle, mfc stays 0, ram_en never asserted. Word at 0x022 -> trap. size=11 at 0x000 -> trap.
- WAIT_CYCLES=0: load halfword at 0x1FE holding bytes 0x12,0x34 -> ram_addr 0x1FE then 0x1FF in consecutive cycles; rdata=0x00001234; mfc 3 cycles after request.
- Hold mfa high 10 cycles after mfc -> exactly one mfc pulse and one RAM access sequence. Drop mfa for one cycle and raise it again -> a second access is accepted.
- Assert reset during slot 2 of a word store -> ram_en/ram_we low the same instant, busy=0, no mfc. After reset release, a new byte load completes normally.
